ghr_spec_ctrl: RTL and testbench
================================

Name: ghr_spec_ctrl

Overview:
- Speculation controller sitting between the DEC/EX stages and the global history register.
- Checkpoints the GHR value and the predicted direction for every branch that enters DEC.
- Gates the GHR speculative shift, and matches each EX-stage resolution against the oldest in-flight branch.
- On a mispredict, sequences GHR repair: restores the checkpoint plus the real outcome and squashes younger in-flight entries.

Parameters:
- BPRED_WIDTH, 9, GHR width in bits.
- DEPTH, 4, maximum in-flight unresolved branches; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_DEC_Is_Branch  in  1  branch instruction present in DEC this cycle.
- i_Prediction  in  1  predicted direction from the counter table (1 = taken).
- i_Global_History  in  BPRED_WIDTH  current GHR value; checkpointed on push.
- i_ALU_Branch_Valid  in  1  branch resolving in EX this cycle.
- i_ALU_Branch_Outcome  in  1  resolved direction (1 = taken).
- o_GHR_Shift_En  out  1  combinational; shift o_GHR_Shift_Bit into the GHR this cycle.
- o_GHR_Shift_Bit  out  1  combinational; equals i_Prediction.
- o_GHR_Restore_En  out  1  registered one-cycle pulse; load o_GHR_Restore_Value into the GHR.
- o_GHR_Restore_Value  out  BPRED_WIDTH  registered; {checkpoint[BPRED_WIDTH-2:0], outcome}.
- o_Mispredict  out  1  registered one-cycle pulse, coincident with o_GHR_Restore_En.
- o_DEC_Stall  out  1  combinational; asserted when the FIFO is full or state is RECOVER.
- o_Inflight_Count  out  PTR_W+1  registered FIFO occupancy.
- o_Underflow  out  1  registered, sticky; set when a resolution arrives with the FIFO empty.

Behaviour:
- Reset: FIFO empty, count 0, state RUN. All registered outputs 0, o_GHR_Restore_Value = 0. Reset overrides everything, including mid-recovery.
- FIFO entry: {checkpoint[BPRED_WIDTH-1:0], pred}. Circular head/tail pointers wrap modulo DEPTH.
- Push (accept): i_DEC_Is_Branch & ~o_DEC_Stall.
  - o_GHR_Shift_En = accept, in the same cycle.
  - The entry is written at the rising edge.
  - A branch arriving while stalled is neither checkpointed nor shifted; the DEC stage must hold it.
- Pop: i_ALU_Branch_Valid with count > 0. Pops the head and compares pred against i_ALU_Branch_Outcome.
- Pop with an empty FIFO: ignored, and o_Underflow is set (sticky until reset).
- Correct prediction: the head is retired; no GHR action.
- Mispredict at cycle N, edge N→N+1:
  - All entries are flushed, including a push accepted in cycle N (wrong path).
  - Count becomes 0.
  - State moves to RECOVER.
- Cycle N+1:
  - o_GHR_Restore_En = 1, o_Mispredict = 1.
  - o_GHR_Restore_Value = {head.checkpoint[BPRED_WIDTH-2:0], outcome}.
- FSM:
  - RUN → RECOVER on mispredict.
  - RECOVER → RUN unconditionally after 1 cycle.
  - In RECOVER, o_DEC_Stall = 1 and pops are ignored.
- Simultaneous push and correct pop: both take effect; count is unchanged. With the FIFO full, the stall still holds, because the stall is driven from the registered count.
- Count arithmetic: count_next = count + push − pop, or 0 on mispredict. Never exceeds DEPTH.

Optional Feature:
- Macro GHR_SPEC_STATS_EN.
- When defined:
  - Adds outputs o_Branch_Count[15:0] (every valid pop) and o_Mispredict_Count[15:0].
  - Both are 16-bit saturating at 16'hFFFF and cleared by i_Reset.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ghr_spec_pkg holds:
  - the BPRED_WIDTH default;
  - the entry typedef {checkpoint, pred};
  - the state enum {ST_RUN, ST_RECOVER}.
- One sub-module: ghr_ckpt_fifo, a DEPTH-entry checkpoint FIFO with push, pop and flush inputs and head, count and full outputs. The controller holds the FSM, comparison and output registers.

Test Plan:
- Reset: i_Reset=1 for 2 cycles, then 0 → count 0, o_DEC_Stall 0, all pulses 0.
- Push/resolve correct:
  - DEC branch, pred=0, GHR=9'h0A5 → o_GHR_Shift_En=1 the same cycle, count=1.
  - EX valid, outcome=0 → count=0, no restore.
- Mispredict repair:
  - Push pred=0 with GHR=9'h0A5, then EX outcome=1 → next cycle o_GHR_Restore_En=1, o_Mispredict=1, value=9'h14B.
  - o_DEC_Stall=1 for 1 cycle.
- Two in flight:
  - Push pred=1 (GHR=9'h001), then push pred=0 (GHR=9'h003).
  - Resolve outcome=1 concurrently with a third push → count stays 2.
  - Resolve outcome=1 → restore value=9'h007; count becomes 0, and the third entry is flushed.
- Full and wrap:
  - Push 4 → o_DEC_Stall=1; a 5th branch gives o_GHR_Shift_En=0.
  - Pop 2, push 2 → pointers wrap; FIFO order is preserved on pops.
- Underflow and reset mid-recovery:
  - EX valid with count 0 → o_Underflow=1 and stays set.
  - i_Reset asserted in the RECOVER cycle → state RUN and o_Underflow cleared next cycle.

Source files
------------

// File: rtl/ghr_spec_pkg.sv
// ghr_spec_pkg
// Shared types and defaults for the GHR speculation controller.
//   GHR_BPRED_WIDTH : default global-history width in bits
//   ghr_entry_t     : checkpoint FIFO entry {checkpoint, pred} at the default width
//   ghr_state_e     : controller FSM states
//   sat_inc16       : 16-bit saturating increment used by the optional
//                     statistics counters (GHR_SPEC_STATS_EN)
package ghr_spec_pkg;

  localparam int GHR_BPRED_WIDTH = 9;

  typedef struct packed {
    logic [GHR_BPRED_WIDTH-1:0] checkpoint;
    logic                       pred;
  } ghr_entry_t;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } ghr_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// ghr_ckpt_fifo
// DEPTH-entry circular FIFO holding {checkpoint, pred} for every in-flight
// branch. Flush empties the FIFO and wins over a same-cycle push or pop.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data at the tail (ignored when full or flushing)
//   push_data   : entry to store
//   pop         : retire the head entry (ignored when empty or flushing)
//   flush       : discard every entry, pointers back to 0
//   head        : oldest entry (combinational read of the head slot)
//   count       : registered occupancy, 0..DEPTH
//   full        : count == DEPTH
module ghr_ckpt_fifo #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [PTR_W:0]    count,
  output logic              full
);

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  head_ptr_r;
  logic [PTR_W-1:0]  tail_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              full_s;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify push/pop against occupancy and flush
  always_comb begin
    full_s    = (count_r == (PTR_W+1)'(DEPTH));
    do_push_s = push & ~flush & ~full_s;
    do_pop_s  = pop & ~flush & (count_r != CNT_ZERO);
  end

  // Entry storage; contents beyond count are don't-care so no reset needed
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[tail_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_ptr_r <= {PTR_W{1'b0}};
      tail_ptr_r <= {PTR_W{1'b0}};
      count_r    <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        tail_ptr_r <= tail_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        head_ptr_r <= head_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[head_ptr_r];
  assign count = count_r;
  assign full  = full_s;

endmodule

// File: rtl/ghr_spec_ctrl.sv
// ghr_spec_ctrl
// Speculation controller between DEC/EX and the global history register.
// Checkpoints GHR + prediction for each accepted DEC branch, gates the
// speculative GHR shift, resolves EX branches against the oldest in-flight
// entry and, on a mispredict, issues a one-cycle GHR repair while flushing
// all younger (wrong-path) entries.
// Optional: define GHR_SPEC_STATS_EN to add o_Branch_Count and
// o_Mispredict_Count (16-bit saturating).
// Ports:
//   i_Clk, i_Reset          : clock, synchronous active-high reset
//   i_DEC_Is_Branch         : branch in DEC this cycle
//   i_Prediction            : predicted direction (1 = taken)
//   i_Global_History        : current GHR, checkpointed on accept
//   i_ALU_Branch_Valid      : branch resolving in EX this cycle
//   i_ALU_Branch_Outcome    : resolved direction
//   o_GHR_Shift_En/_Bit     : combinational speculative shift request
//   o_GHR_Restore_En/_Value : registered repair pulse and value
//   o_Mispredict            : registered pulse with the repair
//   o_DEC_Stall             : combinational, FIFO full or recovering
//   o_Inflight_Count        : registered FIFO occupancy
//   o_Underflow             : sticky, resolution seen with nothing in flight
module ghr_spec_ctrl
  import ghr_spec_pkg::*;
#(
  parameter int BPRED_WIDTH = GHR_BPRED_WIDTH,
  parameter int DEPTH       = 4,
  parameter int PTR_W       = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_DEC_Is_Branch,
  input  logic                   i_Prediction,
  input  logic [BPRED_WIDTH-1:0] i_Global_History,
  input  logic                   i_ALU_Branch_Valid,
  input  logic                   i_ALU_Branch_Outcome,
  output logic                   o_GHR_Shift_En,
  output logic                   o_GHR_Shift_Bit,
  output logic                   o_GHR_Restore_En,
  output logic [BPRED_WIDTH-1:0] o_GHR_Restore_Value,
  output logic                   o_Mispredict,
  output logic                   o_DEC_Stall,
  output logic [PTR_W:0]         o_Inflight_Count,
  output logic                   o_Underflow
`ifdef GHR_SPEC_STATS_EN
  ,
  output logic [15:0]            o_Branch_Count,
  output logic [15:0]            o_Mispredict_Count
`endif
);

  localparam int ENTRY_W = BPRED_WIDTH + 1;
  localparam logic [PTR_W:0] CNT_ZERO = {(PTR_W+1){1'b0}};

  ghr_state_e             state_r;
  logic [ENTRY_W-1:0]     head_s;
  logic [PTR_W:0]         count_s;
  logic                   full_s;
  logic                   stall_s;
  logic                   accept_s;
  logic                   resolve_s;
  logic                   pop_valid_s;
  logic                   mispredict_s;
  logic                   retire_s;
  logic                   ckpt_msb_unused_s;
  logic                   restore_en_r;
  logic                   mispredict_r;
  logic                   underflow_r;
  logic [BPRED_WIDTH-1:0] restore_value_r;

  // The checkpoint MSB shifts out of the GHR on repair, so it is never read
  assign ckpt_msb_unused_s = head_s[ENTRY_W-1];

  // Accept/resolve decode; stall depends only on registered state so a
  // same-cycle pop never opens a slot for a push
  always_comb begin
    stall_s      = full_s | (state_r == ST_RECOVER);
    accept_s     = i_DEC_Is_Branch & ~stall_s;
    resolve_s    = i_ALU_Branch_Valid & (state_r == ST_RUN);
    pop_valid_s  = resolve_s & (count_s != CNT_ZERO);
    mispredict_s = pop_valid_s & (head_s[0] != i_ALU_Branch_Outcome);
    retire_s     = pop_valid_s & ~mispredict_s;
  end

  ghr_ckpt_fifo #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .DATA_W (ENTRY_W)
  ) u_ckpt_fifo (
    .clk       (i_Clk),
    .reset     (i_Reset),
    .push      (accept_s),
    .push_data ({i_Global_History, i_Prediction}),
    .pop       (retire_s),
    .flush     (mispredict_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s)
  );

  // FSM plus registered repair pulse, repair value and sticky underflow
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r         <= ST_RUN;
      restore_en_r    <= 1'b0;
      mispredict_r    <= 1'b0;
      restore_value_r <= {BPRED_WIDTH{1'b0}};
      underflow_r     <= 1'b0;
    end else begin
      restore_en_r <= mispredict_s;
      mispredict_r <= mispredict_s;
      if (mispredict_s) begin
        // Checkpoint taken before this branch shifted, so append the real outcome
        restore_value_r <= {head_s[ENTRY_W-2:1], i_ALU_Branch_Outcome};
      end
      if (resolve_s && (count_s == CNT_ZERO)) begin
        underflow_r <= 1'b1;
      end
      case (state_r)
        ST_RUN: begin
          if (mispredict_s) begin
            state_r <= ST_RECOVER;
          end
        end
        ST_RECOVER: state_r <= ST_RUN;
        default:    state_r <= ST_RUN;
      endcase
    end
  end

`ifdef GHR_SPEC_STATS_EN
  logic [15:0] branch_count_r;
  logic [15:0] mispredict_count_r;

  // Saturating resolution statistics
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      branch_count_r     <= 16'd0;
      mispredict_count_r <= 16'd0;
    end else begin
      if (pop_valid_s) begin
        branch_count_r <= sat_inc16(branch_count_r);
      end
      if (mispredict_s) begin
        mispredict_count_r <= sat_inc16(mispredict_count_r);
      end
    end
  end

  assign o_Branch_Count     = branch_count_r;
  assign o_Mispredict_Count = mispredict_count_r;
`endif

  assign o_GHR_Shift_En      = accept_s;
  assign o_GHR_Shift_Bit     = i_Prediction;
  assign o_GHR_Restore_En    = restore_en_r;
  assign o_GHR_Restore_Value = restore_value_r;
  assign o_Mispredict        = mispredict_r;
  assign o_DEC_Stall         = stall_s;
  assign o_Inflight_Count    = count_s;
  assign o_Underflow         = underflow_r;

endmodule

// File: tb/tb_ghr_spec_ctrl.sv
// tb_ghr_spec_ctrl
// Self-checking bench for ghr_spec_ctrl. A small queue model tracks in-flight
// branches; expected repair values are pushed to a scoreboard queue when a
// mispredicting resolution is driven and popped when the DUT raises
// o_GHR_Restore_En.
module tb_ghr_spec_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_DEC_Is_Branch;
  logic       i_Prediction;
  logic [8:0] i_Global_History;
  logic       i_ALU_Branch_Valid;
  logic       i_ALU_Branch_Outcome;
  logic       o_GHR_Shift_En;
  logic       o_GHR_Shift_Bit;
  logic       o_GHR_Restore_En;
  logic [8:0] o_GHR_Restore_Value;
  logic       o_Mispredict;
  logic       o_DEC_Stall;
  logic [2:0] o_Inflight_Count;
  logic       o_Underflow;
`ifdef GHR_SPEC_STATS_EN
  logic [15:0] o_Branch_Count;
  logic [15:0] o_Mispredict_Count;
`endif

  ghr_spec_ctrl dut (
    .i_Clk                (i_Clk),
    .i_Reset              (i_Reset),
    .i_DEC_Is_Branch      (i_DEC_Is_Branch),
    .i_Prediction         (i_Prediction),
    .i_Global_History     (i_Global_History),
    .i_ALU_Branch_Valid   (i_ALU_Branch_Valid),
    .i_ALU_Branch_Outcome (i_ALU_Branch_Outcome),
    .o_GHR_Shift_En       (o_GHR_Shift_En),
    .o_GHR_Shift_Bit      (o_GHR_Shift_Bit),
    .o_GHR_Restore_En     (o_GHR_Restore_En),
    .o_GHR_Restore_Value  (o_GHR_Restore_Value),
    .o_Mispredict         (o_Mispredict),
    .o_DEC_Stall          (o_DEC_Stall),
    .o_Inflight_Count     (o_Inflight_Count),
    .o_Underflow          (o_Underflow)
`ifdef GHR_SPEC_STATS_EN
    ,
    .o_Branch_Count       (o_Branch_Count),
    .o_Mispredict_Count   (o_Mispredict_Count)
`endif
  );

  // Free-running clock
  always #5 i_Clk = ~i_Clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [9:0] model_q[$];
  logic [8:0] exp_restore_q[$];
  bit         m_rec    = 1'b0;
  bit         m_under  = 1'b0;
  int         m_branches = 0;
  int         m_misp     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock of stimulus; called at posedge+1, returns at next posedge+1
  task automatic cycle(input logic rst, input logic br, input logic pred,
                       input logic [8:0] ghr, input logic alu_v, input logic outc);
    bit         stall_e;
    bit         acc;
    bit         mis;
    logic [9:0] hd;
    i_Reset              = rst;
    i_DEC_Is_Branch      = br;
    i_Prediction         = pred;
    i_Global_History     = ghr;
    i_ALU_Branch_Valid   = alu_v;
    i_ALU_Branch_Outcome = outc;
    #3;
    stall_e = (model_q.size() == 4) || m_rec;
    acc     = br && !stall_e;
    check("shift_en", o_GHR_Shift_En, acc);
    check("dec_stall", o_DEC_Stall, stall_e);
    check("shift_bit", o_GHR_Shift_Bit, pred);
    mis = 1'b0;
    if (!rst && alu_v && !m_rec) begin
      if (model_q.size() == 0) begin
        m_under = 1'b1;
      end else begin
        hd = model_q[0];
        m_branches++;
        if (hd[0] !== outc) begin
          mis = 1'b1;
          m_misp++;
          exp_restore_q.push_back({hd[8:1], outc});
        end else begin
          void'(model_q.pop_front());
        end
      end
    end
    @(posedge i_Clk);
    #1;
    if (rst) begin
      model_q.delete();
      exp_restore_q.delete();
      m_rec = 1'b0; m_under = 1'b0; m_branches = 0; m_misp = 0;
    end else if (mis) begin
      model_q.delete();
      m_rec = 1'b1;
    end else begin
      if (acc) model_q.push_back({ghr, pred});
      m_rec = 1'b0;
    end
    check("inflight", o_Inflight_Count, model_q.size());
    check("restore_en", o_GHR_Restore_En, mis);
    check("mispredict", o_Mispredict, mis);
    check("underflow", o_Underflow, m_under);
    if (o_GHR_Restore_En) begin
      if (exp_restore_q.size() == 0) check("restore_unexpected", o_GHR_Restore_En, 1'b0);
      else check("restore_value", o_GHR_Restore_Value, exp_restore_q.pop_front());
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
  endtask

  initial begin
    i_Reset = 1'b1; i_DEC_Is_Branch = 1'b0; i_Prediction = 1'b0;
    i_Global_History = 9'h000; i_ALU_Branch_Valid = 1'b0; i_ALU_Branch_Outcome = 1'b0;
    repeat (2) @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
    #3;
    check("rst_count", o_Inflight_Count, 3'd0);
    check("rst_stall", o_DEC_Stall, 1'b0);
    check("rst_restore_en", o_GHR_Restore_En, 1'b0);
    check("rst_mispredict", o_Mispredict, 1'b0);
    check("rst_restore_val", o_GHR_Restore_Value, 9'h000);
    check("rst_underflow", o_Underflow, 1'b0);
    @(posedge i_Clk);
    #1;

    // Push then correct resolve
    cycle(1'b0, 1'b1, 1'b0, 9'h0A5, 1'b0, 1'b0);
    check("t1_count1", o_Inflight_Count, 3'd1);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0);
    check("t1_count0", o_Inflight_Count, 3'd0);

    // Mispredict repair, branch during RECOVER is dropped
    cycle(1'b0, 1'b1, 1'b0, 9'h0A5, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    check("t2_restore_val", o_GHR_Restore_Value, 9'h14B);
    check("t2_restore_en", o_GHR_Restore_En, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 9'h055, 1'b0, 1'b0);
    idle();

    // Two in flight, correct pop with concurrent push, then mispredict flush
    cycle(1'b0, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 9'h003, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 9'h007, 1'b1, 1'b1);
    check("t3_count2", o_Inflight_Count, 3'd2);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    check("t3_restore_val", o_GHR_Restore_Value, 9'h007);
    check("t3_count0", o_Inflight_Count, 3'd0);
    idle();

    // Fill, stall, wrap, ordered drain
    cycle(1'b0, 1'b1, 1'b1, 9'h010, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 9'h011, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 9'h012, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 9'h013, 1'b0, 1'b0);
    check("t4_full_count", o_Inflight_Count, 3'd4);
    cycle(1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 9'h020, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 9'h0F0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 9'h100, 1'b1, 1'b1);
    check("t4_full_pop_push", o_Inflight_Count, 3'd3);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    check("t4_wrap_restore", o_GHR_Restore_Value, 9'h1E1);
    idle();

    // Underflow is sticky; reset during RECOVER clears everything
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0);
    idle();
    check("t5_underflow_sticky", o_Underflow, 1'b1);
`ifdef GHR_SPEC_STATS_EN
    check("stats_branches", o_Branch_Count, m_branches);
    check("stats_misp", o_Mispredict_Count, m_misp);
`endif
    cycle(1'b0, 1'b1, 1'b0, 9'h0A5, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    check("t5_underflow_clr", o_Underflow, 1'b0);
    idle();
    cycle(1'b0, 1'b1, 1'b1, 9'h0C3, 1'b0, 1'b0);
    check("t5_run_after_rst", o_Inflight_Count, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
